cdb_arbiter: RTL

- Master (driving) end of the common data bus (CDB).
- Collects completed results from the ALU, MDU and LSU execution units, buffers them in a small FIFO per source, and broadcasts at most one (tag, wdata) per cycle.
- Round-robin arbitration across sources.
- The ROB and the reservation stations are the CDB slaves and consume the registered broadcast.

---
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// CDB master: per-source result FIFOs with round-robin broadcast of one (tag, wdata) per cycle.
// Optional macro CDB_BYPASS_EN lets an empty source's incoming result go straight to the bus.
module cdb_arbiter #(
  parameter int TAG_W      = 4,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*TAG_W-1:0] src_tag,
  input  logic [NUM_SRC*32-1:0]    src_wdata,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     cdb_wr,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [31:0]              cdb_wdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [TAG_W-1:0] tag_mem_q [NUM_SRC][FIFO_DEPTH];
  logic [31:0]      dat_mem_q [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] rptr_q [NUM_SRC];
  logic [PTR_W-1:0] rptr_d [NUM_SRC];
  logic [PTR_W-1:0] wptr_q [NUM_SRC];
  logic [PTR_W-1:0] wptr_d [NUM_SRC];
  logic [CNT_W-1:0] cnt_q  [NUM_SRC];
  logic [CNT_W-1:0] cnt_d  [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_wr_q, cdb_wr_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [31:0]      cdb_wdata_q, cdb_wdata_d;

  logic [NUM_SRC-1:0] accept, cand, push, pop;
  logic [TAG_W-1:0]   head_tag [NUM_SRC];
  logic [31:0]        head_dat [NUM_SRC];
  logic               gnt_vld;
  logic [SRC_W-1:0]   gnt_idx;
  logic [TAG_W-1:0]   gnt_tag;
  logic [31:0]        gnt_dat;

  // Tag 0 means "no result": such transfers are handshaken but never stored.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = rst && (cnt_q[i] != FULL);
      accept[i]    = src_valid[i] && src_ready[i] && (src_tag[i*TAG_W +: TAG_W] != '0);
`ifdef CDB_BYPASS_EN
      cand[i]     = (cnt_q[i] != '0) || accept[i];
      head_tag[i] = (cnt_q[i] != '0) ? tag_mem_q[i][rptr_q[i]] : src_tag[i*TAG_W +: TAG_W];
      head_dat[i] = (cnt_q[i] != '0) ? dat_mem_q[i][rptr_q[i]] : src_wdata[i*32 +: 32];
`else
      cand[i]     = (cnt_q[i] != '0);
      head_tag[i] = tag_mem_q[i][rptr_q[i]];
      head_dat[i] = dat_mem_q[i][rptr_q[i]];
`endif
    end
  end

  // Round robin as two ordered passes: rr_ptr..NUM_SRC-1, then 0..rr_ptr-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_tag = '0;
    gnt_dat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!gnt_vld && cand[i] && (i >= int'(rr_ptr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(i);
        gnt_tag = head_tag[i];
        gnt_dat = head_dat[i];
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!gnt_vld && cand[i] && (i < int'(rr_ptr_q))) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(i);
        gnt_tag = head_tag[i];
        gnt_dat = head_dat[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]  = gnt_vld && (gnt_idx == SRC_W'(i)) && (cnt_q[i] != '0);
      // A granted result from an empty FIFO was bypassed and must not also be stored.
      push[i] = accept[i] && !(gnt_vld && (gnt_idx == SRC_W'(i)) && (cnt_q[i] == '0));
      rptr_d[i] = rptr_q[i] + PTR_W'(pop[i]);
      wptr_d[i] = wptr_q[i] + PTR_W'(push[i]);
      cnt_d[i]  = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
    rr_ptr_d    = rr_ptr_q;
    cdb_wr_d    = gnt_vld;
    cdb_tag_d   = cdb_tag_q;
    cdb_wdata_d = cdb_wdata_q;
    if (gnt_vld) begin
      rr_ptr_d    = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
      cdb_tag_d   = gnt_tag;
      cdb_wdata_d = gnt_dat;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wptr_q[i]] <= src_tag[i*TAG_W +: TAG_W];
        dat_mem_q[i][wptr_q[i]] <= src_wdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_wr_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rptr_q[i] <= rptr_d[i];
        wptr_q[i] <= wptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_wr_q    <= cdb_wr_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_wdata_q <= cdb_wdata_d;
    end
  end

  assign cdb_wr    = cdb_wr_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_wdata = cdb_wdata_q;

endmodule
